// File: rtl/fft_input_reorder_if.sv
// Sample-in / frame-out bundle of the FFT input reorder buffer.
// slave = reorder block, master = the upstream source and FFT engine driving its inputs.
interface fft_input_reorder_if #(
    parameter int AW = 3
);
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_last;
    logic          in_ready;
    logic          out_frame_valid;
    logic          out_bank;
    logic [AW-1:0] out_rd_addr;
    logic [31:0]   out_rd_data;
    logic          out_frame_done;
    logic          frame_err;

    modport slave (
        input  in_valid, in_data, in_last, out_rd_addr, out_frame_done,
        output in_ready, out_frame_valid, out_bank, out_rd_data, frame_err
    );

    modport master (
        output in_valid, in_data, in_last, out_rd_addr, out_frame_done,
        input  in_ready, out_frame_valid, out_bank, out_rd_data, frame_err
    );
endinterface

// File: rtl/fft_input_reorder.sv
// Ping-pong buffer writing samples at bit-reversed addresses; read data 1 clk after address.
// in_ready drops only while the write bank still holds an unreleased frame (both banks FULL).
module fft_input_reorder #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_input_reorder_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_st_e;

    bank_st_e [1:0] bank_st_q, bank_st_d;
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [AW-1:0]  wr_cnt_q, wr_cnt_d;
    logic           frame_err_q, frame_err_d;
    logic [31:0]    rd_data_q, rd_data_d;

    logic [31:0]    mem [2*N];

    logic           wr_full, rd_full;
    logic           xfer, release_ok, last_slot;
    logic [AW-1:0]  wr_addr;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_st_q[0] <= EMPTY;
            bank_st_q[1] <= EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_cnt_q     <= '0;
            frame_err_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            bank_st_q    <= bank_st_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            frame_err_q  <= frame_err_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Storage is never cleared; a bank's contents only matter once it is FULL.
    always_ff @(posedge clk) begin
        if (rst_n && xfer) begin
            mem[{wr_bank_q, wr_addr}] <= bus.in_data;
        end
    end

    always_comb begin
        xfer        = bus.in_valid && !wr_full;
        release_ok  = bus.out_frame_done && rd_full;
        last_slot   = (wr_cnt_q == AW'(N - 1));
        wr_addr     = bitrev(wr_cnt_q);

        bank_st_d   = bank_st_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        frame_err_d = xfer && (bus.in_last != last_slot);
        rd_data_d   = mem[{rd_bank_q, bus.out_rd_addr}];

        if (xfer) begin
            if (last_slot) begin
                bank_st_d[wr_bank_q] = FULL;
                wr_cnt_d             = '0;
                wr_bank_d            = !wr_bank_q;
            end else begin
                bank_st_d[wr_bank_q] = FILLING;
                wr_cnt_d             = wr_cnt_q + AW'(1);
            end
        end

        // A release always hits a FULL bank and a write never does, so both may land together.
        if (release_ok) begin
            bank_st_d[rd_bank_q] = EMPTY;
            rd_bank_d            = !rd_bank_q;
        end
    end

    always_comb begin
        wr_full             = (bank_st_q[wr_bank_q] == FULL);
        rd_full             = (bank_st_q[rd_bank_q] == FULL);
        bus.in_ready        = !wr_full;
        bus.out_frame_valid = rd_full;
        bus.out_bank        = rd_bank_q;
        bus.out_rd_data     = rd_data_q;
        bus.frame_err       = frame_err_q;
    end
endmodule

// File: tb/tb_fft_input_reorder.sv
// Bench for fft_input_reorder: frame-queue reference model plus directed scenarios, N=8 and N=32.
module tb_fft_input_reorder;
    localparam int N   = 8;
    localparam int AW  = 3;
    localparam int N32 = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fft_input_reorder_if #(.AW(AW)) bus ();
    fft_input_reorder_if #(.AW(5))  bus32 ();

    fft_input_reorder #(.N(N))   dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    fft_input_reorder #(.N(N32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int tb_rev(input int k, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (k % 2);
            k = k / 2;
        end
        return r;
    endfunction

    // Reference model: completed frames queue in arrival order, at most two held at once.
    logic [N*32-1:0] frames [$];
    logic [N*32-1:0] part;
    int              psize    = 0;
    int              released = 0;
    logic [31:0]     exp_rd;
    bit              rd_known = 1'b0;
    bit              exp_err  = 1'b0;
    bit              live     = 1'b0;
    bit              m_ready, m_valid;
    logic            m_rst, m_v, m_l, m_done;
    logic [31:0]     m_d;
    logic [AW-1:0]   m_a;

    always @(posedge clk) begin
        m_rst  = rst_n;
        m_v    = bus.in_valid;
        m_d    = bus.in_data;
        m_l    = bus.in_last;
        m_done = bus.out_frame_done;
        m_a    = bus.out_rd_addr;
        #1;
        if (!m_rst) begin
            frames.delete();
            psize    = 0;
            released = 0;
            exp_rd   = '0;
            rd_known = 1'b1;
            exp_err  = 1'b0;
            live     = 1'b1;
        end else if (live) begin
            m_ready  = frames.size() < 2;
            m_valid  = frames.size() > 0;
            rd_known = m_valid;
            if (m_valid) exp_rd = frames[0][tb_rev(int'(m_a), AW)*32 +: 32];
            exp_err  = m_v && m_ready && (m_l != (psize == N - 1));
            if (m_done && m_valid) begin
                void'(frames.pop_front());
                released++;
            end
            if (m_v && m_ready) begin
                part[psize*32 +: 32] = m_d;
                psize++;
                if (psize == N) begin
                    frames.push_back(part);
                    psize = 0;
                end
            end
        end
        if (live) begin
            chk("mdl_in_ready", 32'(bus.in_ready), 32'(frames.size() < 2));
            chk("mdl_out_frame_valid", 32'(bus.out_frame_valid), 32'(frames.size() > 0));
            chk("mdl_out_bank", 32'(bus.out_bank), 32'(released % 2));
            chk("mdl_frame_err", 32'(bus.frame_err), 32'(exp_err));
            if (rd_known) chk("mdl_out_rd_data", bus.out_rd_data, exp_rd);
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic l,
                         input logic done, input logic [AW-1:0] a);
        @(negedge clk);
        bus.in_valid       = v;
        bus.in_data        = d;
        bus.in_last        = l;
        bus.out_frame_done = done;
        bus.out_rd_addr    = a;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_frame_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_frame_valid"}, 32'(bus.out_frame_valid), 32'd0);
        chk({tag, "_out_bank"}, 32'(bus.out_bank), 32'd0);
        chk({tag, "_out_rd_data"}, bus.out_rd_data, 32'd0);
        chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.out_frame_done = 1'b0; bus.out_rd_addr = '0;
        bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_last = 1'b0;
        bus32.out_frame_done = 1'b0; bus32.out_rd_addr = '0;

        // Traffic during reset must be ignored.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 32'h1234_5678; bus.out_frame_done = 1'b1;
        settle();
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.out_frame_done = 1'b0;

        // One clean frame, then bit-reversed reads.
        for (int k = 0; k < 8; k++) drive(1'b1, {16'(k), 16'h0}, k == 7, 1'b0, 3'd0);
        settle();
        chk("f0_valid", 32'(bus.out_frame_valid), 32'd1);
        chk("f0_bank", 32'(bus.out_bank), 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd1); settle();
        chk("rd_addr1", bus.out_rd_data, 32'h0004_0000);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd3); settle();
        chk("rd_addr3", bus.out_rd_data, 32'h0006_0000);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd6); settle();
        chk("rd_addr6", bus.out_rd_data, 32'h0003_0000);

        // Second frame fills bank 1: both full, 17th sample held until a release.
        for (int k = 8; k < 16; k++) drive(1'b1, {16'(k), 16'h0}, k == 15, 1'b0, 3'd0);
        settle();
        chk("both_full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 3'd0); settle();
        chk("held_in_ready", 32'(bus.in_ready), 32'd0);
        chk("held_bank", 32'(bus.out_bank), 32'd0);
        drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b1, 3'd0); settle();
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_bank", 32'(bus.out_bank), 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);

        // Misplaced in_last: error after k=5 and after k=7, frame still completes at k=7.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'(k), k == 5, 1'b0, 3'd0);
            settle();
            chk($sformatf("err_k%0d", k), 32'(bus.frame_err), 32'((k == 5) || (k == 7)));
        end
        chk("err_frame_valid", 32'(bus.out_frame_valid), 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);

        // Final write into bank 1 coincides with release of bank 0.
        do_reset();
        for (int k = 0; k < 15; k++) drive(1'b1, 32'(k), (k % 8) == 7, 1'b0, 3'd0);
        drive(1'b1, 32'd15, 1'b1, 1'b1, 3'd0);
        settle();
        chk("swap_bank", 32'(bus.out_bank), 32'd1);
        chk("swap_valid", 32'(bus.out_frame_valid), 32'd1);
        chk("swap_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);

        // Reset after a partial frame, then a clean frame lands in bank 0.
        do_reset();
        for (int k = 0; k < 3; k++) drive(1'b1, 32'hBEEF_0000 + 32'(k), 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.out_frame_done = 1'b1;
        settle();
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.out_frame_done = 1'b0;
        for (int k = 0; k < 8; k++) drive(1'b1, 32'h100 + 32'(k), k == 7, 1'b0, 3'd0);
        settle();
        chk("clean_valid", 32'(bus.out_frame_valid), 32'd1);
        chk("clean_bank", 32'(bus.out_bank), 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd1); settle();
        chk("clean_rd_addr1", bus.out_rd_data, 32'h104);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            drive($urandom_range(0, 3) != 0, $urandom,
                  (psize == N - 1) ^ ($urandom_range(0, 11) == 0),
                  $urandom_range(0, 4) == 0, AW'($urandom));
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0);

        // N=32 instance: sample k must read back at address bitrev5(k).
        for (int k = 0; k < N32; k++) begin
            @(negedge clk);
            bus32.in_valid = 1'b1; bus32.in_data = 32'(k); bus32.in_last = (k == N32 - 1);
        end
        @(negedge clk);
        bus32.in_valid = 1'b0; bus32.in_last = 1'b0;
        settle();
        chk("n32_valid", 32'(bus32.out_frame_valid), 32'd1);
        for (int k = 0; k < N32; k++) begin
            @(negedge clk);
            bus32.out_rd_addr = 5'(tb_rev(k, 5));
            settle();
            chk($sformatf("n32_k%0d", k), bus32.out_rd_data, 32'(k));
        end
        @(negedge clk);
        bus32.out_rd_addr = 5'd16;
        settle();
        chk("n32_addr16", bus32.out_rd_data, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fft_input_reorder.md
FFT_INPUT_REORDER -- requirements
Module: fft_input_reorder

Interface
REQ-001 Parameter: N, default 8, FFT length in complex points; legal values 8, 16, 32.
REQ-002 Parameter: AW, default log2(N), address width (3/4/5); derived, never overridden independently.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  upstream sample present.
REQ-006 in_data  input  32  complex sample: [31:16] real FP16, [15:0] imag FP16; stored unmodified.
REQ-007 in_last  input  1  upstream end-of-frame marker, qualified by in_valid.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 out_frame_valid  output  1  a complete bit-reversed frame is readable.
REQ-010 out_bank  output  1  index of bank currently presented to the FFT.
REQ-011 out_rd_addr  input  AW  FFT read address into the presented bank.
REQ-012 out_rd_data  output  32  registered read data.
REQ-013 out_frame_done  input  1  single-cycle pulse from FFT: presented frame consumed.
REQ-014 frame_err  output  1  single-cycle pulse: in_last misaligned with frame boundary.

Function
REQ-015 Two banks (ping-pong) of N x 32-bit storage; each bank state EMPTY, FILLING or FULL.
REQ-016 Transfer occurs when in_valid && in_ready; in_ready = 1 iff write bank (wr_bank) is not FULL.
REQ-017 Write address = bit-reverse of AW-bit sample counter wr_cnt; sample k of a frame lands at position bitrev(k).
REQ-018 First transfer into an EMPTY bank moves it to FILLING; wr_cnt increments per transfer.
REQ-019 Transfer with wr_cnt == N-1: bank -> FULL, wr_cnt -> 0, wr_bank toggles, all in the same edge.
REQ-020 Frame length fixed at N transfers; in_last never terminates a frame early.
REQ-021 frame_err pulses for one cycle, the cycle after the transfer, if in_last=1 with wr_cnt != N-1, or in_last=0 with wr_cnt == N-1; data still stored.
REQ-022 out_frame_valid = 1 iff bank rd_bank is FULL; out_bank = rd_bank.
REQ-023 out_rd_data <= bank[rd_bank][out_rd_addr] every cycle; latency 1 clk; read occurs regardless of out_frame_valid (contents undefined when not valid).
REQ-024 out_frame_done with out_frame_valid=1: bank rd_bank -> EMPTY, rd_bank toggles, next edge.
REQ-025 out_frame_done with out_frame_valid=0: ignored, no state change.
REQ-026 Same-cycle fill completion on one bank and release of the other: both take effect; no lost frame.
REQ-027 Both banks FULL: in_ready=0; release of rd_bank re-asserts in_ready next cycle.
REQ-028 Single bank scenario: fill completing onto bank equal to rd_bank raises out_frame_valid the cycle after the final transfer.
REQ-029 No write ever targets a FULL bank; no read bank switch occurs without out_frame_done.
REQ-030 Throughput: one sample per cycle sustained while consumer releases within N cycles.

Reset
REQ-031 rst_n=0 at an edge: both banks EMPTY, wr_bank=0, rd_bank=0, wr_cnt=0, in_ready=1 after reset, out_frame_valid=0, out_bank=0, out_rd_data=0, frame_err=0.
REQ-032 Reset mid-frame discards partial and full frames; storage contents not cleared, treated invalid.
REQ-033 Transfers and out_frame_done presented during reset are ignored.

Verification
REQ-034 N=8, 8 transfers in_data={k,16'h0}, k=0..7, in_last on k=7 -> out_frame_valid=1 next cycle; addr 1 returns real 4, addr 3 returns real 6, addr 6 returns real 3 one cycle after address.
REQ-035 N=8, 16 back-to-back samples, no out_frame_done -> in_ready=0 after 16th transfer; 17th sample held; one out_frame_done -> in_ready=1 next cycle, out_bank=1.
REQ-036 in_last on k=5 of an 8-sample frame -> frame_err pulses once after k=5 and once after k=7; frame still completes at k=7.
REQ-037 Final transfer into bank 1 on same cycle as out_frame_done for bank 0 -> next cycle rd_bank=1, out_frame_valid=1, bank 0 EMPTY, in_ready=1.
REQ-038 rst_n=0 after 3 transfers -> all outputs at reset values; following 8 samples form a clean frame in bank 0.
REQ-039 N=32 parameterisation: sample k read back at address bitrev5(k) for all k, e.g. k=1 at address 16.
